regfile_mp: RTL

Parametrised multi-port general-purpose register file, successor to the fixed 32x32 single-write register file in the decode stage.
- Generalises data width, register count, read-port count and write-port count.
- Adds optional write-to-read bypass, deterministic multi-write priority and a registered write-conflict flag.
- Sits in ID: read ports feed operand fetch; write ports are driven from WB, and from MEM on dual-issue configurations.

---
 rtl/regfile_mp_pkg.sv | 28 ++
 rtl/regfile_bypass_mux.sv | 44 ++++
 rtl/regfile_mp.sv | 137 +++++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// ============================================================================
// regfile_mp_pkg : shared register-file types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_mp_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic REG_ENABLE = 1'b1;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO_ADDR = '0;

   typedef logic                  reg_en_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   // Default-width write request; the top declares a width-matched twin.
   typedef struct packed {
      reg_en_t   en;
      reg_addr_t addr;
      reg_data_t data;
   } wr_port_t;

endpackage

`default_nettype wire

// File: rtl/regfile_bypass_mux.sv
// ============================================================================
// regfile_bypass_mux : per-read-port data select (enable, zero reg, bypass)
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_bypass_mux
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_WR   = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic [DATA_W-1:0]        rd_stored,
   input  logic [NUM_WR-1:0]        wr_eff,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0]        rd_data
);

   always_comb begin
      rd_data = rd_stored;
      // Ascending scan so the highest-index matching write port wins.
      for (int j = 0; j < NUM_WR; j++) begin
         if ((BYPASS != 0) && wr_eff[j] &&
             (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
            rd_data = wr_data[j*DATA_W +: DATA_W];
         end
      end
      if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO_ADDR))) begin
         rd_data = '0;
      end
      if (rd_en != REG_ENABLE) begin
         rd_data = '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : parametrised multi-port register file with optional bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   output logic                     wr_conflict
);

   localparam int DEPTH = 2**ADDR_W;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic [DATA_W-1:0]   regs_d [DEPTH];
   logic                run_q;
   logic                run_d;
   logic                wr_conflict_q;
   logic                wr_conflict_d;

   wr_req_t [NUM_WR-1:0] w_wr_req;
   logic    [NUM_WR-1:0] w_wr_eff;

   // Writes to the zero register are dropped here, before priority/conflict.
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         w_wr_req[j].addr = wr_addr[j*ADDR_W +: ADDR_W];
         w_wr_req[j].data = wr_data[j*DATA_W +: DATA_W];
         w_wr_req[j].en   = wr_en[j] &&
                            !((ZERO_REG != 0) &&
                              (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO_ADDR)));
         w_wr_eff[j]      = w_wr_req[j].en;
      end
   end

   // run_q stays low through the first edge after release so that edge writes nothing.
   assign run_d = 1'b1;

   always_comb begin
      regs_d = regs_q;
      if (run_q) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (w_wr_req[j].en) begin
               regs_d[w_wr_req[j].addr] = w_wr_req[j].data;
            end
         end
      end
   end

   generate
      if (NUM_WR > 1) begin : g_conflict
         always_comb begin
            wr_conflict_d = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
               for (int k = j + 1; k < NUM_WR; k++) begin
                  if (w_wr_req[j].en && w_wr_req[k].en &&
                      (w_wr_req[j].addr == w_wr_req[k].addr)) begin
                     wr_conflict_d = 1'b1;
                  end
               end
            end
            if (!run_q) begin
               wr_conflict_d = 1'b0;
            end
         end
      end else begin : g_no_conflict
         assign wr_conflict_d = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= '0;
         end
         run_q         <= 1'b0;
         wr_conflict_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         run_q         <= run_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign wr_conflict = wr_conflict_q;

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [ADDR_W-1:0] w_rd_addr;
         logic [DATA_W-1:0] w_rd_stored;

         assign w_rd_addr   = rd_addr[i*ADDR_W +: ADDR_W];
         assign w_rd_stored = regs_q[w_rd_addr];

         regfile_bypass_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
         ) u_bypass_mux (
            .rd_en     (rd_en[i]),
            .rd_addr   (w_rd_addr),
            .rd_stored (w_rd_stored),
            .wr_eff    (w_wr_eff),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_data   (rd_data[i*DATA_W +: DATA_W])
         );
      end
   endgenerate

endmodule

`default_nettype wire
